// File: rtl/mmult_opt_mdc_ctrl_pkg.sv
// Shared types and default widths for the mmult_opt_mdc job controller.
package mmult_opt_mdc_ctrl_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int CNT_W_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;
endpackage

// File: rtl/mmult_opt_mdc_beat_cnt.sv
// Per-port beat counter: counts accepted beats up to a latched length and flags
// when the port may still accept traffic.
module mmult_opt_mdc_beat_cnt
   import mmult_opt_mdc_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             en,
   input  logic             inc,
   input  logic [CNT_W-1:0] len,
   output logic [CNT_W-1:0] cnt,
   output logic             act
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Gating inc by act is what makes the counter saturate at len.
   assign act = en & (cnt_q < len);
   assign cnt = cnt_q;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (clear)            cnt_d = '0;
      else if (inc && act)  cnt_d = cnt_q + 1'b1;
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
endmodule

// File: rtl/mmult_opt_mdc_job_ctrl.sv
// Job sequencer gating two source streams into the network and draining results
// to a sink. Optional performance counters: define MMULT_CTRL_PERF_CNT_EN.
module mmult_opt_mdc_job_ctrl
   import mmult_opt_mdc_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cfg_start,
   input  logic              cfg_abort,
   input  logic [CNT_W-1:0]  cfg_len_in1,
   input  logic [CNT_W-1:0]  cfg_len_in2,
   input  logic [CNT_W-1:0]  cfg_len_out,
   output logic              busy,
   output logic              done,
   input  logic [DATA_W-1:0] src1_data,
   input  logic              src1_valid,
   output logic              src1_ready,
   input  logic [DATA_W-1:0] src2_data,
   input  logic              src2_valid,
   output logic              src2_ready,
   output logic [DATA_W-1:0] net_in1_data,
   output logic              net_in1_wr,
   input  logic              net_in1_full,
   output logic [DATA_W-1:0] net_in2_data,
   output logic              net_in2_wr,
   input  logic              net_in2_full,
   input  logic [DATA_W-1:0] net_out_data,
   input  logic              net_out_wr,
   output logic              net_out_full,
   output logic [DATA_W-1:0] snk_data,
   output logic              snk_valid,
   input  logic              snk_ready,
   output logic [31:0]       perf_cycles,
   output logic [31:0]       perf_stalls
);
   state_e           state_q, state_d;
   logic [CNT_W-1:0] len_in1_q, len_in1_d, len_in2_q, len_in2_d, len_out_q, len_out_d;
   logic [CNT_W-1:0] cnt_in1, cnt_in2, cnt_out;
   logic             act_1, act_2, act_o, run, start_acc, cnt_clear, all_met;

   assign run       = (state_q == RUN);
   assign start_acc = (state_q == IDLE) & cfg_start & ~cfg_abort;
   assign cnt_clear = start_acc | cfg_abort;
   assign all_met   = (cnt_in1 == len_in1_q) & (cnt_in2 == len_in2_q) & (cnt_out == len_out_q);

   always_comb begin
      state_d   = state_q;
      len_in1_d = len_in1_q;
      len_in2_d = len_in2_q;
      len_out_d = len_out_q;
      if (start_acc) begin
         len_in1_d = cfg_len_in1;
         len_in2_d = cfg_len_in2;
         len_out_d = cfg_len_out;
      end
      unique case (state_q)
         IDLE:    if (start_acc) state_d = RUN;
         RUN:     if (all_met)   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (cfg_abort) state_d = IDLE;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         len_in1_q <= '0;
         len_in2_q <= '0;
         len_out_q <= '0;
      end else begin
         state_q   <= state_d;
         len_in1_q <= len_in1_d;
         len_in2_q <= len_in2_d;
         len_out_q <= len_out_d;
      end
   end

   assign busy         = run;
   assign done         = (state_q == DONE);
   assign src1_ready   = act_1 & ~net_in1_full;
   assign net_in1_wr   = act_1 & src1_valid & ~net_in1_full;
   assign net_in1_data = src1_data;
   assign src2_ready   = act_2 & ~net_in2_full;
   assign net_in2_wr   = act_2 & src2_valid & ~net_in2_full;
   assign net_in2_data = src2_data;
   // net_out_full is an accept strobe towards the network, not a "full" flag.
   assign net_out_full = act_o & snk_ready;
   assign snk_valid    = act_o & net_out_wr;
   assign snk_data     = net_out_data;

   mmult_opt_mdc_beat_cnt #(.CNT_W(CNT_W)) u_cnt_in1 (
      .clock(clock), .reset(reset), .clear(cnt_clear), .en(run),
      .inc(net_in1_wr), .len(len_in1_q), .cnt(cnt_in1), .act(act_1));
   mmult_opt_mdc_beat_cnt #(.CNT_W(CNT_W)) u_cnt_in2 (
      .clock(clock), .reset(reset), .clear(cnt_clear), .en(run),
      .inc(net_in2_wr), .len(len_in2_q), .cnt(cnt_in2), .act(act_2));
   mmult_opt_mdc_beat_cnt #(.CNT_W(CNT_W)) u_cnt_out (
      .clock(clock), .reset(reset), .clear(cnt_clear), .en(run),
      .inc(snk_valid & snk_ready), .len(len_out_q), .cnt(cnt_out), .act(act_o));

`ifdef MMULT_CTRL_PERF_CNT_EN
   logic [31:0] cyc_q, cyc_d, stl_q, stl_d;
   logic        stall;

   assign stall = (src1_valid & act_1 & net_in1_full) | (src2_valid & act_2 & net_in2_full)
                | (snk_valid & ~snk_ready);

   always_comb begin
      cyc_d = cyc_q;
      stl_d = stl_q;
      if (start_acc) begin
         cyc_d = '0;
         stl_d = '0;
      end else if (run) begin
         if (cyc_q != 32'hFFFF_FFFF)          cyc_d = cyc_q + 32'd1;
         if (stall && stl_q != 32'hFFFF_FFFF) stl_d = stl_q + 32'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cyc_q <= '0;
         stl_q <= '0;
      end else begin
         cyc_q <= cyc_d;
         stl_q <= stl_d;
      end
   end

   assign perf_cycles = cyc_q;
   assign perf_stalls = stl_q;
`else
   assign perf_cycles = '0;
   assign perf_stalls = '0;
`endif
endmodule
